// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The SERIAL_SUB_OVF_EN macro enables the signed overflow output.
package serial_sub_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow of a - b, judged from the operand and result sign bits.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// The overflow signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if;
    import serial_sub_pkg::*;

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             overflow;

    modport master (output start, A, B, borrow_in,
                    input  busy, done, Y, borrow_out, overflow);
    modport slave  (input  start, A, B, borrow_in,
                    output busy, done, Y, borrow_out, overflow);
`else
    modport master (output start, A, B, borrow_in,
                    input  busy, done, Y, borrow_out);
    modport slave  (input  start, A, B, borrow_in,
                    output busy, done, Y, borrow_out);
`endif

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial 8-bit subtractor: one bit per cycle, LSB first, through a single
// full_subtractor cell. SERIAL_SUB_OVF_EN adds a registered signed-overflow flag.
module serial_subtractor
    import serial_sub_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    serial_subtractor_if.slave  bus
);

    localparam logic [1:0]       S_IDLE   = IDLE;
    localparam logic [1:0]       S_RUN    = RUN;
    localparam logic [1:0]       S_DONE   = DONE;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] d_sr;
    logic             bin_q;
    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] y_q;
    logic             bo_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Control and visible results; the result registers move only on the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            y_q   <= '0;
            bo_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= S_DONE;
                        y_q   <= {d_bit, d_sr};
                        bo_q  <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit the shifters present the operand sign bits.
                        ovf_q <= sub_ovf(a_sr[0], b_sr[0], d_bit);
`endif
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand shifters and partial difference; no reset needed, loaded on start.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.start) begin
            a_sr  <= bus.A;
            b_sr  <= bus.B;
            bin_q <= bus.borrow_in;
        end else if (state == S_RUN) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            bin_q <= bout_bit;
            d_sr  <= {d_bit, d_sr[WIDTH-2:1]};
        end
    end

    assign bus.busy       = (state == S_RUN);
    assign bus.done       = (state == S_DONE);
    assign bus.Y          = y_q;
    assign bus.borrow_out = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor; overflow checks compile in
// only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_y = 8'h00;

    always #5 clk = ~clk;

    serial_subtractor_if bus ();

    serial_subtractor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation from a start pulse; checks latency, busy length, hold, results.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bi, input logic [7:0] ey, input logic eb,
                          input bit chg, input bit rel_rst);
        int cyc;
        int bcnt;
        @(negedge clk);
        if (rel_rst) reset = 1'b0;
        bus.start     = 1'b1;
        bus.A         = a;
        bus.B         = b;
        bus.borrow_in = bi;
        @(negedge clk);
        bus.start = 1'b0;
        cyc  = 1;
        bcnt = 0;
        while (!bus.done && cyc < 20) begin
            if (bus.busy) bcnt++;
            if (cyc == 4) check({tag, "_hold"}, {24'h0, bus.Y}, {24'h0, last_y});
            if (chg && cyc == 2) bus.A = 8'hFF;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"},  cyc, 9);
        check({tag, "_busy"}, bcnt, 8);
        check({tag, "_y"},    {24'h0, bus.Y}, {24'h0, ey});
        check({tag, "_bo"},   {31'h0, bus.borrow_out}, {31'h0, eb});
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"},  {31'h0, bus.overflow},
              {31'h0, (a[7] != b[7]) && (ey[7] != a[7])});
`endif
        @(negedge clk);
        check({tag, "_pulse"}, {30'h0, bus.done, bus.busy}, 32'h0);
        last_y = ey;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn;
        int t1;
        int t2;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_y",    {24'h0, bus.Y}, 32'h0);
        check("rst_bo",   {31'h0, bus.borrow_out}, 32'h0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf",  {31'h0, bus.overflow}, 32'h0);
`endif
        reset = 1'b0;

        run_op("s3c_14", 8'h3C, 8'h14, 1'b0, 8'h28, 1'b0, 1'b0, 1'b0);
        run_op("s00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("s05_05", 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("s7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0);
        run_op("s50_20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1, 1'b0);

        // start held high continuously
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h10;
        bus.B     = 8'h01;
        bus.borrow_in = 1'b0;
        dn = 0; t1 = 0; t2 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dn++;
                if (dn == 1) t1 = k;
                if (dn == 2) t2 = k;
            end
        end
        bus.start = 1'b0;
        check("held_count", dn, 4);
        check("held_gap",   t2 - t1, 10);
        check("held_y",     {24'h0, bus.Y}, 32'h0F);
        check("held_bo",    {31'h0, bus.borrow_out}, 32'h0);

        // start pulses while RUN/DONE must not queue another operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h3C;
        bus.B     = 8'h14;
        @(negedge clk);
        dn = 0;
        for (int k = 1; k <= 25; k++) begin
            bus.start = ((k >= 2 && k <= 7 && (k % 2 == 1)) || k == 8);
            if (bus.done) dn++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("pulse_count", dn, 1);
        check("pulse_y",     {24'h0, bus.Y}, 32'h28);

        // reset in the 4th RUN cycle aborts the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h10;
        bus.B     = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_done", {31'h0, bus.done}, 32'h0);
        check("abort_y",    {24'h0, bus.Y}, 32'h0);
        reset = 1'b0;
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort_nodone", dn, 0);
        last_y = 8'h00;
        reset = 1'b1;
        @(negedge clk);
        run_op("s80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        run_op("s10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
